pc_seq: RTL and testbench

Program-counter sequencer for the RISC CPU fetch path. It owns the PC register, resolves branch and jump requests from decode, and drives the select line of the next-PC 2:1 mux (0 = sequential PC, 1 = branch target). It also issues a one-cycle pipeline flush on every taken branch and reports busy to decode while a branch is being resolved.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_seq_br_cmp.sv | 25 ++
 rtl/pc_seq.sv | 109 ++++++++++
 tb/tb_pc_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: branch types and FSM states.
package pc_seq_pkg;

  // br_type encodings presented by decode
  localparam logic [1:0] BR_BEQ = 2'b00;
  localparam logic [1:0] BR_BNE = 2'b01;
  localparam logic [1:0] BR_JMP = 2'b10;
  localparam logic [1:0] BR_RSV = 2'b11;

  // FSM state encodings
  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_RESOLVE = 2'b01;

  // width of the optional taken-branch counter
  localparam int STATS_W = 16;

endpackage

// File: rtl/pc_seq_br_cmp.sv
// Branch resolver: decides whether a captured branch/jump is taken.
// Purely combinational; operands compare as unsigned bitwise equality.
module br_cmp
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [1:0]       br_type,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             taken
);

  // decode branch type against operand equality; reserved type never taken
  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_BEQ: taken = (rs_val == rt_val);
      BR_BNE: taken = (rs_val != rt_val);
      BR_JMP: taken = 1'b1;
      BR_RSV: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer for the fetch path: owns the PC, resolves
// branches/jumps from decode and drives the next-PC mux select, flush
// and busy. Optional macro PC_SEQ_STATS_EN adds a saturating count of
// taken branches on port br_taken_cnt.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | sequential fetch; accepts a branch request from decode
//   ST_RESOLVE | captured branch being resolved; pc_sel/flush valid here
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [1:0]        br_type,
  input  logic [WIDTH-1:0]  rs_val,
  input  logic [WIDTH-1:0]  rt_val,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_sel,
  output logic              flush,
`ifdef PC_SEQ_STATS_EN
  output logic              busy,
  output logic [STATS_W-1:0] br_taken_cnt
`else
  output logic              busy
`endif
);

  localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  logic [1:0]        state;
  logic [1:0]        cap_type;
  logic [WIDTH-1:0]  cap_rs;
  logic [WIDTH-1:0]  cap_rt;
  logic [ADDR_W-1:0] cap_target;
  logic [ADDR_W-1:0] pc_q;
  logic              taken;
  logic              in_resolve;

  br_cmp #(
    .WIDTH (WIDTH)
  ) u_br_cmp (
    .br_type (cap_type),
    .rs_val  (cap_rs),
    .rt_val  (cap_rt),
    .taken   (taken)
  );

  // outputs derive from state and captured operands only, so reset
  // mid-resolve drops flush immediately
  always_comb begin
    in_resolve = (state == ST_RESOLVE);
    pc_sel     = in_resolve & taken;
    flush      = in_resolve & taken & ~stall;
    busy       = (state != ST_RUN);
    pc         = pc_q;
  end

  // PC register, FSM and branch capture; stall freezes all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      pc_q       <= PC_RST;
      cap_type   <= '0;
      cap_rs     <= '0;
      cap_rt     <= '0;
      cap_target <= '0;
    end else if (!stall) begin
      case (state)
        ST_RUN: begin
          if (br_valid) begin
            cap_type   <= br_type;
            cap_rs     <= rs_val;
            cap_rt     <= rt_val;
            cap_target <= br_target;
            state      <= ST_RESOLVE;
          end else begin
            pc_q <= pc_q + PC_ONE;
          end
        end
        ST_RESOLVE: begin
          pc_q  <= taken ? cap_target : (pc_q + PC_ONE);
          state <= ST_RUN;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef PC_SEQ_STATS_EN
  // saturating count of taken branches, one per flush pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_taken_cnt <= '0;
    end else if (flush && (br_taken_cnt != {STATS_W{1'b1}})) begin
      br_taken_cnt <= br_taken_cnt + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: transaction-level model plus directed
// vectors with literal expectations. Define PC_SEQ_STATS_EN to also
// check br_taken_cnt.
module tb_pc_seq;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        br_valid;
  logic [1:0]  br_type;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [7:0]  br_target;
  logic [7:0]  pc;
  logic        pc_sel;
  logic        flush;
  logic        busy;
`ifdef PC_SEQ_STATS_EN
  logic [15:0] br_taken_cnt;
`endif

  int n_pass  = 0;
  int n_total = 0;

  pc_seq #(
    .WIDTH    (16),
    .ADDR_W   (8),
    .RESET_PC (0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_type   (br_type),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .br_target (br_target),
    .pc        (pc),
    .pc_sel    (pc_sel),
    .flush     (flush),
`ifdef PC_SEQ_STATS_EN
    .busy      (busy),
    .br_taken_cnt (br_taken_cnt)
`else
    .busy      (busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  m_pc   = 8'h00;
  bit          m_pend = 1'b0;
  logic [1:0]  m_type = 2'b00;
  logic [15:0] m_rs   = 16'h0;
  logic [15:0] m_rt   = 16'h0;
  logic [7:0]  m_tgt  = 8'h00;
  int          m_cnt  = 0;

  function automatic bit rule_taken(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b);
    case (t)
      2'b00:   return a == b;
      2'b01:   return a != b;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 8'h00; m_pend = 0; m_type = 0; m_rs = 0; m_rt = 0; m_tgt = 0; m_cnt = 0;
    end else if (!stall) begin
      if (m_pend) begin
        if (rule_taken(m_type, m_rs, m_rt)) begin
          m_pc = m_tgt;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          m_pc = m_pc + 8'd1;
        end
        m_pend = 0;
      end else if (br_valid) begin
        m_type = br_type; m_rs = rs_val; m_rt = rt_val; m_tgt = br_target;
        m_pend = 1;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  end

  // compare DUT against model every cycle, away from the rising edge
  always @(negedge clk) begin
    bit tk;
    tk = m_pend && rule_taken(m_type, m_rs, m_rt);
    chk("model_pc", {24'h0, pc}, {24'h0, m_pc});
    chk("model_busy", {31'h0, busy}, {31'h0, m_pend});
    chk("model_pc_sel", {31'h0, pc_sel}, {31'h0, tk});
    chk("model_flush", {31'h0, flush}, {31'h0, tk && !stall});
`ifdef PC_SEQ_STATS_EN
    chk("model_cnt", {16'h0, br_taken_cnt}, m_cnt);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  // called at posedge+1; leaves the bench at posedge+1 with pc == n
  task automatic reset_to(input int n);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (n) cyc();
  endtask

  task automatic br(input logic [1:0] t, input logic [15:0] a, input logic [15:0] b, input logic [7:0] tg);
    br_type = t; rs_val = a; rt_val = b; br_target = tg; br_valid = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; br_valid = 1'b0; br_type = 2'b00;
    rs_val = '0; rt_val = '0; br_target = '0;
    #1 rst_n = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_pc", {24'h0, pc}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_pc_sel", {31'h0, pc_sel}, 32'h0);
    chk("rst_flush", {31'h0, flush}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // sequential fetch 0..4
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("seq_pc", {24'h0, pc}, i);
      chk("seq_busy", {31'h0, busy}, 32'h0);
      cyc();
    end

    // BEQ taken at pc=3
    reset_to(3);
    br(2'b00, 16'h00A5, 16'h00A5, 8'h40);
    @(negedge clk); chk("beq_pc_n", {24'h0, pc}, 32'h3);
    cyc(); br_valid = 1'b0;
    @(negedge clk);
    chk("beq_pc_n1", {24'h0, pc}, 32'h3);
    chk("beq_busy", {31'h0, busy}, 32'h1);
    chk("beq_pc_sel", {31'h0, pc_sel}, 32'h1);
    chk("beq_flush", {31'h0, flush}, 32'h1);
    cyc();
    @(negedge clk);
    chk("beq_pc_n2", {24'h0, pc}, 32'h40);
    chk("beq_flush_off", {31'h0, flush}, 32'h0);

    // BNE not taken at pc=5
    cyc();
    reset_to(5);
    br(2'b01, 16'h1234, 16'h1234, 8'h80);
    @(negedge clk); chk("bne_pc_n", {24'h0, pc}, 32'h5);
    cyc(); br_valid = 1'b0;
    @(negedge clk);
    chk("bne_pc_n1", {24'h0, pc}, 32'h5);
    chk("bne_pc_sel", {31'h0, pc_sel}, 32'h0);
    chk("bne_flush", {31'h0, flush}, 32'h0);
    chk("bne_busy", {31'h0, busy}, 32'h1);
    cyc();
    @(negedge clk); chk("bne_pc_n2", {24'h0, pc}, 32'h6);

    // jump to FE, then wrap through FF to 00
    br(2'b10, 16'h0, 16'h0, 8'hFE);
    cyc(); br_valid = 1'b0;
    cyc();
    @(negedge clk); chk("wrap_fe", {24'h0, pc}, 32'hFE);
    cyc(); @(negedge clk); chk("wrap_ff", {24'h0, pc}, 32'hFF);
    cyc(); @(negedge clk); chk("wrap_00", {24'h0, pc}, 32'h00);

    // JMP at pc=1, stalled 3 cycles in resolve, request held by decode
    cyc();
    br(2'b10, 16'h0, 16'h0, 8'h22);
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stl_pc", {24'h0, pc}, 32'h1);
      chk("stl_pc_sel", {31'h0, pc_sel}, 32'h1);
      chk("stl_flush", {31'h0, flush}, 32'h0);
      cyc();
    end
    stall = 1'b0;
    @(negedge clk);
    chk("stl_flush_fire", {31'h0, flush}, 32'h1);
    chk("stl_pc_hold", {24'h0, pc}, 32'h1);
    br_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("stl_pc_tgt", {24'h0, pc}, 32'h22);
    chk("stl_busy_off", {31'h0, busy}, 32'h0);

    // stall and br_valid together: nothing captured
    cyc();
    stall = 1'b1;
    br(2'b00, 16'h0001, 16'h0002, 8'h50);
    @(negedge clk); chk("sv_busy0", {31'h0, busy}, 32'h0);
    cyc(); stall = 1'b0;
    @(negedge clk);
    chk("sv_busy1", {31'h0, busy}, 32'h0);
    chk("sv_pc1", {24'h0, pc}, 32'h23);
    cyc(); br_valid = 1'b0;
    @(negedge clk);
    chk("sv_busy2", {31'h0, busy}, 32'h1);
    chk("sv_pc_sel", {31'h0, pc_sel}, 32'h0);
    cyc();
    @(negedge clk); chk("sv_pc_next", {24'h0, pc}, 32'h24);

    // reserved type never taken, even with equal operands
    cyc();
    br(2'b11, 16'h0007, 16'h0007, 8'h90);
    cyc(); br_valid = 1'b0;
    @(negedge clk); chk("rsv_pc_sel", {31'h0, pc_sel}, 32'h0);
    cyc();
    @(negedge clk); chk("rsv_pc", {24'h0, pc}, 32'h26);

    // self-loop branch at pc=0x27
    cyc();
    br(2'b00, 16'h0005, 16'h0005, 8'h27);
    cyc(); br_valid = 1'b0;
    @(negedge clk); chk("self_flush", {31'h0, flush}, 32'h1);
    cyc();
    @(negedge clk);
    chk("self_pc", {24'h0, pc}, 32'h27);
    chk("self_busy", {31'h0, busy}, 32'h0);

    // reset asserted mid-resolve of a taken BEQ
    cyc();
    br(2'b00, 16'h0009, 16'h0009, 8'h60);
    cyc(); br_valid = 1'b0;
    @(negedge clk); chk("mid_pc_sel", {31'h0, pc_sel}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_pc", {24'h0, pc}, 32'h0);
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_flush", {31'h0, flush}, 32'h0);
    @(negedge clk); chk("mid_flush2", {31'h0, flush}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // three taken jumps
    for (int k = 1; k <= 3; k++) begin
      br(2'b10, 16'h0, 16'h0, 8'(k * 16));
      cyc(); br_valid = 1'b0;
      cyc();
    end
    @(negedge clk);
    chk("cnt_pc", {24'h0, pc}, 32'h30);
`ifdef PC_SEQ_STATS_EN
    chk("cnt_taken", {16'h0, br_taken_cnt}, 32'h3);
`endif

    repeat (2) cyc();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
